// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and control-word type for the multicycle MIPS main control.
// ADDI_EN adds the ADDI_EX/ADDI_WB states and the ADDI opcode path.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BRN_PC   = 4'd8,
    BEQ_EX   = 4'd9,
    JUMP     = 4'd10
`ifdef ADDI_EN
    ,
    ADDI_EX  = 4'd11,
    ADDI_WB  = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the main-control FSM (master) and the datapath/ALU-control side (slave).
// op and brn flow into the controller; everything else is a datapath control line.
interface multicycle_control_if;
  logic [5:0] op;
  logic       brn;
  logic       aluop1;
  logic       aluop0;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       pcwrite;
  logic       pcwritecond;
  logic [1:0] pcsource;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;

  modport master (
    input  op, brn,
    output aluop1, aluop0, alusrca, alusrcb, pcwrite, pcwritecond, pcsource,
           iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite
  );

  modport slave (
    output op, brn,
    input  aluop1, aluop0, alusrca, alusrcb, pcwrite, pcwritecond, pcsource,
           iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Moore output decoder: maps the current state to the datapath control word.
// Reset blanks every control line so nothing is written while reset is held.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   reset,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        FETCH: begin
          ctrl.memread  = 1'b1;
          ctrl.irwrite  = 1'b1;
          ctrl.alusrcb  = SRCB_FOUR;
          ctrl.pcwrite  = 1'b1;
          ctrl.pcsource = PCSRC_ALU;
          ctrl.aluop    = ALUOP_ADD;
        end
        DECODE: begin
          // Speculative branch target into ALUOut
          ctrl.alusrcb = SRCB_IMM_SH2;
          ctrl.aluop   = ALUOP_ADD;
        end
        MEMADR: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SRCB_IMM;
          ctrl.aluop   = ALUOP_ADD;
        end
        MEMRD: begin
          ctrl.memread = 1'b1;
          ctrl.iord    = 1'b1;
        end
        MEMWB: begin
          ctrl.regwrite = 1'b1;
          ctrl.memtoreg = 1'b1;
        end
        MEMWR: begin
          ctrl.memwrite = 1'b1;
          ctrl.iord     = 1'b1;
        end
        RTYPE_EX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SRCB_B;
          ctrl.aluop   = ALUOP_FUNCT;
        end
        RTYPE_WB: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
        end
        BRN_PC: begin
          // ALUOut holds rs+0 from RTYPE_EX
          ctrl.pcwrite  = 1'b1;
          ctrl.pcsource = PCSRC_ALUOUT;
        end
        BEQ_EX: begin
          ctrl.alusrca     = 1'b1;
          ctrl.alusrcb     = SRCB_B;
          ctrl.aluop       = ALUOP_SUB;
          ctrl.pcwritecond = 1'b1;
          ctrl.pcsource    = PCSRC_ALUOUT;
        end
        JUMP: begin
          ctrl.pcwrite  = 1'b1;
          ctrl.pcsource = PCSRC_JUMP;
        end
`ifdef ADDI_EN
        ADDI_EX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SRCB_IMM;
          ctrl.aluop   = ALUOP_ADD;
        end
        ADDI_WB: begin
          ctrl.regwrite = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main-control FSM: state register, next-state logic and output mapping.
// Define ADDI_EN to add the ADDI execute/write-back states.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus,
  output logic [STATE_W-1:0]     state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = RTYPE_EX;
          OP_BEQ:       state_d = BEQ_EX;
          OP_J:         state_d = JUMP;
`ifdef ADDI_EN
          OP_ADDI:      state_d = ADDI_EX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW)      state_d = MEMRD;
        else if (bus.op == OP_SW) state_d = MEMWR;
        else                      state_d = FETCH;
      end
      MEMRD:    state_d = MEMWB;
      // brn is only meaningful while the ALU-control decoder sees ALUOp=10
      RTYPE_EX: state_d = bus.brn ? BRN_PC : RTYPE_WB;
`ifdef ADDI_EN
      ADDI_EX:  state_d = ADDI_WB;
`endif
      default:  state_d = FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state (state_q),
    .reset (reset),
    .ctrl  (ctrl)
  );

  assign bus.aluop1      = ctrl.aluop[1];
  assign bus.aluop0      = ctrl.aluop[0];
  assign bus.alusrca     = ctrl.alusrca;
  assign bus.alusrcb     = ctrl.alusrcb;
  assign bus.pcwrite     = ctrl.pcwrite;
  assign bus.pcwritecond = ctrl.pcwritecond;
  assign bus.pcsource    = ctrl.pcsource;
  assign bus.iord        = ctrl.iord;
  assign bus.memread     = ctrl.memread;
  assign bus.memwrite    = ctrl.memwrite;
  assign bus.irwrite     = ctrl.irwrite;
  assign bus.memtoreg    = ctrl.memtoreg;
  assign bus.regdst      = ctrl.regdst;
  assign bus.regwrite    = ctrl.regwrite;

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table of inputs and expected state/controls.
// Works with or without ADDI_EN defined.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state;

  multicycle_control_if bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .state (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        brn;
    logic [19:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Control word order: aluop(2) alusrca alusrcb(2) pcwrite pcwritecond pcsource(2)
  //                     iord memread memwrite irwrite memtoreg regdst regwrite
  function automatic logic [15:0] outs(input state_t s);
    case (s)
      FETCH:    return 16'b00_0_01_1_0_00_0_1_0_1_0_0_0;
      DECODE:   return 16'b00_0_11_0_0_00_0_0_0_0_0_0_0;
      MEMADR:   return 16'b00_1_10_0_0_00_0_0_0_0_0_0_0;
      MEMRD:    return 16'b00_0_00_0_0_00_1_1_0_0_0_0_0;
      MEMWB:    return 16'b00_0_00_0_0_00_0_0_0_0_1_0_1;
      MEMWR:    return 16'b00_0_00_0_0_00_1_0_1_0_0_0_0;
      RTYPE_EX: return 16'b10_1_00_0_0_00_0_0_0_0_0_0_0;
      RTYPE_WB: return 16'b00_0_00_0_0_00_0_0_0_0_0_1_1;
      BRN_PC:   return 16'b00_0_00_1_0_01_0_0_0_0_0_0_0;
      BEQ_EX:   return 16'b01_1_00_0_1_01_0_0_0_0_0_0_0;
      JUMP:     return 16'b00_0_00_1_0_10_0_0_0_0_0_0_0;
`ifdef ADDI_EN
      ADDI_EX:  return 16'b00_1_10_0_0_00_0_0_0_0_0_0_0;
      ADDI_WB:  return 16'b00_0_00_0_0_00_0_0_0_0_0_0_1;
`endif
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic b, input state_t s);
    vec_t v;
    v.rst = r;
    v.op  = o;
    v.brn = b;
    v.exp = {4'(s), (r ? 16'h0000 : outs(s))};
    vecs.push_back(v);
  endtask

  function automatic logic [19:0] sample();
    return {state, bus.aluop1, bus.aluop0, bus.alusrca, bus.alusrcb, bus.pcwrite,
            bus.pcwritecond, bus.pcsource, bus.iord, bus.memread, bus.memwrite,
            bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite};
  endfunction

  initial begin
    logic [5:0]  rop;
    logic [19:0] got;
    logic [19:0] want;
    int          waited;

    bus.op  = OP_LW;
    bus.brn = 1'b0;

    // Reset held two cycles, then LW (brn=1 throughout must be ignored)
    add(1, OP_LW, 0, FETCH);
    add(1, OP_LW, 0, FETCH);
    add(0, OP_LW, 1, FETCH);
    add(0, OP_LW, 1, DECODE);
    add(0, OP_LW, 1, MEMADR);
    add(0, OP_LW, 1, MEMRD);
    add(0, OP_LW, 1, MEMWB);
    // R-type with brn=0, then with brn=1
    add(0, OP_R, 0, FETCH);
    add(0, OP_R, 0, DECODE);
    add(0, OP_R, 0, RTYPE_EX);
    add(0, OP_R, 1, RTYPE_WB);
    add(0, OP_R, 1, FETCH);
    add(0, OP_R, 0, DECODE);
    add(0, OP_R, 1, RTYPE_EX);
    add(0, OP_R, 0, BRN_PC);
    // BEQ then J
    add(0, OP_BEQ, 1, FETCH);
    add(0, OP_BEQ, 1, DECODE);
    add(0, OP_BEQ, 1, BEQ_EX);
    add(0, OP_J, 0, FETCH);
    add(0, OP_J, 0, DECODE);
    add(0, OP_J, 0, JUMP);
    // SW with reset landing in MEMWR
    add(0, OP_SW, 0, FETCH);
    add(0, OP_SW, 0, DECODE);
    add(0, OP_SW, 0, MEMADR);
    add(1, OP_SW, 0, MEMWR);
    add(0, OP_SW, 0, FETCH);
    add(0, OP_SW, 0, DECODE);
    add(0, OP_SW, 0, MEMADR);
    add(0, OP_SW, 0, MEMWR);
    // ADDI: optional feature or NOP
    add(0, OP_ADDI, 0, FETCH);
    add(0, OP_ADDI, 0, DECODE);
`ifdef ADDI_EN
    add(0, OP_ADDI, 0, ADDI_EX);
    add(0, OP_ADDI, 0, ADDI_WB);
`endif
    // Random unknown opcodes behave as NOPs
    for (int k = 0; k < 6; k++) begin
      do rop = 6'($urandom_range(0, 63));
      while (rop == OP_R || rop == OP_LW || rop == OP_SW || rop == OP_BEQ ||
             rop == OP_J || rop == OP_ADDI);
      add(0, rop, 1'($urandom_range(0, 1)), FETCH);
      add(0, rop, 1'($urandom_range(0, 1)), DECODE);
    end
    add(0, OP_R, 0, FETCH);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset   = vecs[i].rst;
      bus.op  = vecs[i].op;
      bus.brn = vecs[i].brn;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL row%0d op=%b rst=%0b: got state=%0d ctrl=%b, need state=%0d ctrl=%b",
                    i, vecs[i].op, vecs[i].rst, got[19:16], got[15:0], want[19:16], want[15:0]);
      if (vecs[i].rst) begin
        total_cnt++;
        if (got[15:0] === 16'h0000) pass_cnt++;
        else $display("FAIL row%0d: controls not blanked under reset, ctrl=%b", i, got[15:0]);
      end
    end

    // Leave FETCH, then assert reset and wait (bounded) for the FSM to return to FETCH
    @(posedge clk);
    #1;
    reset  = 1'b1;
    waited = 0;
    while (state !== 4'(FETCH) && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    total_cnt++;
    if (state === 4'(FETCH) && sample() === {4'(FETCH), 16'h0000}) pass_cnt++;
    else $display("FAIL reset wait expired after %0d cycles: state=%0d ctrl=%b",
                  waited, state, sample() & 20'h0FFFF);
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
